mips_regfile_sb: RTL and testbench

Parametrised successor to the single-cycle MIPS register file. It provides NRD combinational read ports, one write-back port, write-to-read bypass, and a per-register scoreboard of pending load destinations. The scoreboard lets ID stall on operands whose multi-cycle load has not yet returned. It sits between ID (read/stall side) and MEM/WB (write side) of the pipelined core.

---
 rtl/mips_regfile_sb.sv | 106 ++++++++++
 tb/tb_mips_regfile_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: parametrised MIPS register file with NRD combinational read
// ports, one write-back port and a per-register scoreboard of pending loads.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read bypass).
//
// Interface protocol: there is no valid/ready handshake. wr_en and busy_set
// are single-cycle commands, and they are always accepted at the posedge
// where they are high. rd_en qualifies a read port. rd_data and rd_stall are
// valid in the same cycle as rd_en/rd_addr.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_stall,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_addr,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  sb_err
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_n;
  logic [ADDR_W:0]   cnt_q;
  logic              err_q;

  // Writes, sets and clears that target r0 are dropped at the source.
  logic wr_hit;
  logic set_hit;
  logic same_addr;
  logic cnt_inc;
  logic cnt_dec;
  logic err_now;

  assign wr_hit    = wr_en && (wr_addr != '0);
  assign set_hit   = busy_set && (busy_addr != '0);
  assign same_addr = wr_hit && (wr_addr == busy_addr);

  // A set wins over a clear to the same register. The count then moves only
  // when the register was idle before this edge.
  assign cnt_inc = set_hit && !busy[busy_addr];
  assign cnt_dec = wr_hit && busy[wr_addr] && !(set_hit && same_addr);
  // A second load to a still-pending register is a protocol error. It is not
  // an error when the pending load returns in the same cycle.
  assign err_now = set_hit && busy[busy_addr] && !same_addr;

  // Read ports: gated to zero on reset, when disabled, or on r0.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              live;
    logic              byp;
    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign live = !rst && rd_en[i] && (a != '0);
`ifdef RF_BYPASS_EN
    assign byp  = wr_hit && (wr_addr == a);
`else
    assign byp  = 1'b0;
`endif
    assign rd_data[i*DATA_W +: DATA_W] = !live ? '0 : (byp ? wr_data : regs[a]);
    assign rd_stall[i] = live && busy[a] && !byp;
  end

  // Next busy vector: clear on write-back, then set on load issue (set wins).
  always_comb begin
    busy_n = busy;
    if (wr_hit)  busy_n[wr_addr]   = 1'b0;
    if (set_hit) busy_n[busy_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Register array write-back. r0 is never written, so it keeps its reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state: busy bits, pending count and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy  <= busy_n;
      cnt_q <= cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
      if (err_now) err_q <= 1'b1;
    end
  end

  assign busy_cnt = cnt_q;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench for mips_regfile_sb: directed test-plan sequence then
// randomized traffic, all compared against a behavioural model of the
// register file and scoreboard. It tracks RF_BYPASS_EN like the design.
module tb_mips_regfile_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NR  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic [AW:0]       busy_cnt;
  logic              sb_err;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [DW-1:0] mreg [NR];
  logic          mbusy [NR];
  logic          merr;
  int            mcnt;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_stall(rd_stall), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy_cnt(busy_cnt), .sb_err(sb_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic [1:0] en,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic bs, input logic [AW-1:0] ba);
    rst = r; rd_en = en; rd_addr = {a1, a0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    busy_set = bs; busy_addr = ba;
  endtask

  // Expected read result for one port, from the current model state.
  task automatic check_reads();
    for (int i = 0; i < NRD; i++) begin
      int a;
      logic [DW-1:0] ed;
      logic es;
      a = int'(rd_addr[i*AW +: AW]);
      ed = '0;
      es = 1'b0;
      if (!rst && rd_en[i] && a != 0) begin
`ifdef RF_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) begin
          ed = wr_data;
          es = 1'b0;
        end else begin
          ed = mreg[a];
          es = mbusy[a];
        end
`else
        ed = mreg[a];
        es = mbusy[a];
`endif
      end
      chk($sformatf("rd%0d_data r%0d", i, a), 64'(rd_data[i*DW +: DW]), 64'(ed));
      chk($sformatf("rd%0d_stall r%0d", i, a), 64'(rd_stall[i]), 64'(es));
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        mreg[k] = '0;
        mbusy[k] = 1'b0;
      end
      merr = 1'b0;
    end else begin
      if (busy_set && busy_addr != 0 && mbusy[busy_addr] &&
          !(wr_en && wr_addr == busy_addr))
        merr = 1'b1;
      if (wr_en && wr_addr != 0) begin
        mreg[wr_addr] = wr_data;
        mbusy[wr_addr] = 1'b0;
      end
      if (busy_set && busy_addr != 0) mbusy[busy_addr] = 1'b1;
    end
    mcnt = 0;
    for (int k = 0; k < NR; k++) mcnt += int'(mbusy[k]);
  endtask

  // One clock: check combinational reads mid-cycle, apply edge, check registered state.
  task automatic cycle();
    @(negedge clk);
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(mcnt));
    chk("sb_err", 64'(sb_err), 64'(merr));
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    set_in(0, 2'b11, a0, a1, 0, '0, '0, 0, '0);
    cycle();
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin
      mreg[k] = 32'hBAD0_0000 | k;
      mbusy[k] = 1'b1;
    end
    merr = 1'b1;
    mcnt = -1;

    // Reset with write and busy_set active
    set_in(1, 2'b11, 5'd4, 5'd4, 1, 5'd4, 32'hFFFF_FFFF, 1, 5'd4);
    cycle();
    cycle();
    for (int a = 1; a < NR; a += 2) rd2(5'(a), 5'(a + 1));

    // Write / read, r0 immutability
    set_in(0, 2'b00, '0, '0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0); cycle();
    rd2(5'd5, 5'd5);
    set_in(0, 2'b11, 5'd0, 5'd0, 1, 5'd0, 32'h0000_1234, 0, '0); cycle();
    rd2(5'd0, 5'd0);

    // Scoreboard set/clear
    set_in(0, 2'b00, '0, '0, 0, '0, '0, 1, 5'd8); cycle();
    rd2(5'd8, 5'd8);
    set_in(0, 2'b00, '0, '0, 1, 5'd8, 32'h55, 0, '0); cycle();
    rd2(5'd8, 5'd8);

    // Same-cycle read of a busy register being written
    set_in(0, 2'b00, '0, '0, 0, '0, '0, 1, 5'd8); cycle();
    set_in(0, 2'b11, 5'd8, 5'd8, 1, 5'd8, 32'h77, 0, '0); cycle();
    rd2(5'd8, 5'd8);

    // Set/write collision, then double set error
    set_in(0, 2'b00, '0, '0, 0, '0, '0, 1, 5'd3); cycle();
    set_in(0, 2'b11, 5'd3, 5'd3, 1, 5'd3, 32'hAA, 1, 5'd3); cycle();
    rd2(5'd3, 5'd3);
    set_in(0, 2'b00, '0, '0, 0, '0, '0, 1, 5'd3); cycle();
    rd2(5'd3, 5'd1);
    rd2(5'd2, 5'd3);

    // Fill the scoreboard
    set_in(1, 2'b00, '0, '0, 0, '0, '0, 0, '0); cycle();
    for (int a = 1; a < NR; a++) begin
      set_in(0, 2'b11, 5'(a), 5'(a - 1), 0, '0, '0, 1, 5'(a));
      cycle();
    end
    set_in(0, 2'b11, 5'd31, 5'd0, 0, '0, '0, 1, 5'd0); cycle();

    // Randomized traffic; small address pool keeps collisions frequent
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] r0, r1, wa, ba;
      logic sm;
      sm = ($urandom_range(0, 3) != 0);
      r0 = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r1 = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wa = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ba = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), r0, r1,
             ($urandom_range(0, 1) == 1), wa, $urandom,
             ($urandom_range(0, 2) == 0), ba);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
